// File: rtl/ascon_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ascon_pkg
// Description : Shared types and constants for the Ascon permutation layers.
// Revision    : 1.0 - initial release
// ============================================================================
package ascon_pkg;

    // Words x0..x4, index 0 holds x0.
    typedef logic [4:0][63:0] t_state_array;

    // Ascon 5-bit sbox, entry n at index n.
    localparam logic [31:0][4:0] C_LUT_SBOX = {
        5'h17, 5'h0f, 5'h0a, 5'h16, 5'h19, 5'h01, 5'h0c, 5'h10,
        5'h18, 5'h11, 5'h0d, 5'h00, 5'h0e, 5'h07, 5'h13, 5'h1e,
        5'h1c, 5'h06, 5'h03, 5'h1d, 5'h12, 5'h08, 5'h05, 5'h1b,
        5'h02, 5'h09, 5'h15, 5'h1a, 5'h14, 5'h1f, 5'h0b, 5'h04
    };

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SUBST = 2'd1,
        DONE  = 2'd2
    } t_subst_fsm;

endpackage
`default_nettype wire

// File: rtl/substitution_layer_sbox.sv
`default_nettype none
// ============================================================================
// Module      : substitution_layer_sbox
// Description : Single combinational Ascon 5-bit sbox lookup.
// Revision    : 1.0 - initial release
// ============================================================================
module substitution_layer_sbox
    import ascon_pkg::*;
(
    input  logic [4:0] i_x,
    output logic [4:0] o_y
);

    assign o_y = C_LUT_SBOX[i_x];

endmodule
`default_nettype wire

// File: rtl/substitution_layer.sv
`default_nettype none
// ============================================================================
// Module      : substitution_layer
// Description : Iterative Ascon substitution layer, NB_SBOX columns per cycle.
//               Define SUBST_ZEROIZE_EN to clear the result on handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module substitution_layer
    import ascon_pkg::*;
#(
    parameter int NB_SBOX = 8
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         i_valid,
    output logic         o_ready,
    input  t_state_array i_state,
    output logic         o_valid,
    input  logic         i_ready,
    output t_state_array o_state,
    output logic         o_busy
);

    localparam int NB_STEPS = 64 / NB_SBOX;
    localparam int CNT_W    = (NB_STEPS > 1) ? $clog2(NB_STEPS) : 1;
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(NB_STEPS - 1);

    generate
        if (!(NB_SBOX == 1  || NB_SBOX == 2  || NB_SBOX == 4 || NB_SBOX == 8 ||
              NB_SBOX == 16 || NB_SBOX == 32 || NB_SBOX == 64)) begin : g_bad_nb_sbox
            $error("substitution_layer: NB_SBOX must be a power of two in 1..64");
        end
    endgenerate

    t_subst_fsm   fsm_q, fsm_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    t_state_array work_q, work_d;

    logic [6:0] w_base;
    logic [5:0] w_col_idx  [NB_SBOX];
    logic [4:0] w_sbox_in  [NB_SBOX];
    logic [4:0] w_sbox_out [NB_SBOX];

    assign w_base = 7'(cnt_q) * 7'(NB_SBOX);

    generate
        for (genvar gi = 0; gi < NB_SBOX; gi++) begin : g_sbox
            assign w_col_idx[gi] = 6'(w_base + 7'(gi));
            // x0 is the MSB of the column nibble.
            assign w_sbox_in[gi] = {work_q[0][w_col_idx[gi]], work_q[1][w_col_idx[gi]],
                                    work_q[2][w_col_idx[gi]], work_q[3][w_col_idx[gi]],
                                    work_q[4][w_col_idx[gi]]};
            substitution_layer_sbox u_sbox (
                .i_x (w_sbox_in[gi]),
                .o_y (w_sbox_out[gi])
            );
        end
    endgenerate

    always_comb begin
        fsm_d  = fsm_q;
        cnt_d  = cnt_q;
        work_d = work_q;
        case (fsm_q)
            IDLE: begin
                if (i_valid) begin
                    work_d = i_state;
                    cnt_d  = '0;
                    fsm_d  = SUBST;
                end
            end
            SUBST: begin
                for (int i = 0; i < NB_SBOX; i++) begin
                    work_d[0][w_col_idx[i]] = w_sbox_out[i][4];
                    work_d[1][w_col_idx[i]] = w_sbox_out[i][3];
                    work_d[2][w_col_idx[i]] = w_sbox_out[i][2];
                    work_d[3][w_col_idx[i]] = w_sbox_out[i][1];
                    work_d[4][w_col_idx[i]] = w_sbox_out[i][0];
                end
                if (cnt_q == C_CNT_LAST) begin
                    cnt_d = '0;
                    fsm_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                // Returning to IDLE here keeps a new load out of the handshake cycle.
                if (i_ready) begin
                    fsm_d = IDLE;
`ifdef SUBST_ZEROIZE_EN
                    work_d = '0;
`else
                    work_d = work_q;
`endif
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fsm_q  <= IDLE;
            cnt_q  <= '0;
            work_q <= '0;
        end else begin
            fsm_q  <= fsm_d;
            cnt_q  <= cnt_d;
            work_q <= work_d;
        end
    end

    assign o_ready = (fsm_q == IDLE);
    assign o_busy  = (fsm_q == SUBST);
    assign o_valid = (fsm_q == DONE);
    assign o_state = work_q;

endmodule
`default_nettype wire

// File: tb/tb_substitution_layer.sv
`default_nettype none
// ============================================================================
// Module      : tb_substitution_layer
// Description : Self-checking bench for substitution_layer (NB_SBOX 8, 1, 64).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_substitution_layer;
    import ascon_pkg::*;

    localparam int NSTEPS = 8;
    localparam logic [63:0] C_F = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] C_A = 64'hAAAA_AAAA_AAAA_AAAA;

    logic clock = 1'b0;
    logic reset_n = 1'b0;

    logic i_valid = 1'b0, i_ready = 1'b0;
    logic o_ready, o_valid, o_busy;
    t_state_array i_state = '0;
    t_state_array o_state;

    logic va = 1'b0, ra = 1'b1;
    t_state_array sa = '0;
    logic ordy1, ov1, ob1, ordy64, ov64, ob64;
    t_state_array os1, os64;

    int n_checks = 0;
    int n_fail   = 0;

    t_state_array sb8[$], sb1[$], sb64[$];

    logic [4:0] ref_lut [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

    typedef struct {
        t_state_array din;
        t_state_array dexp;
    } vec_t;
    vec_t vecs[7];

    always #5 clock = ~clock;

    substitution_layer #(.NB_SBOX(8)) dut (
        .clock(clock), .reset_n(reset_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_state(i_state), .o_valid(o_valid), .i_ready(i_ready),
        .o_state(o_state), .o_busy(o_busy));

    substitution_layer #(.NB_SBOX(1)) dut1 (
        .clock(clock), .reset_n(reset_n), .i_valid(va), .o_ready(ordy1),
        .i_state(sa), .o_valid(ov1), .i_ready(ra),
        .o_state(os1), .o_busy(ob1));

    substitution_layer #(.NB_SBOX(64)) dut64 (
        .clock(clock), .reset_n(reset_n), .i_valid(va), .o_ready(ordy64),
        .i_state(sa), .o_valid(ov64), .i_ready(ra),
        .o_state(os64), .o_busy(ob64));

    function automatic t_state_array mk(input logic [63:0] a0, a1, a2, a3, a4);
        t_state_array r;
        r[0] = a0; r[1] = a1; r[2] = a2; r[3] = a3; r[4] = a4;
        return r;
    endfunction

    function automatic t_state_array rand_state();
        t_state_array r;
        for (int k = 0; k < 5; k++) r[k] = {$urandom, $urandom};
        return r;
    endfunction

    function automatic t_state_array ref_subst(input t_state_array s);
        t_state_array r;
        logic [4:0] a, b;
        for (int j = 0; j < 64; j++) begin
            a = {s[0][j], s[1][j], s[2][j], s[3][j], s[4][j]};
            b = ref_lut[a];
            r[0][j] = b[4]; r[1][j] = b[3]; r[2][j] = b[2]; r[3][j] = b[1]; r[4][j] = b[0];
        end
        return r;
    endfunction

    task automatic check(input string nm, input logic [319:0] act, input logic [319:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic t_state_array after_hs(input t_state_array kept);
`ifdef SUBST_ZEROIZE_EN
        return '0;
`else
        return kept;
`endif
    endfunction

    task automatic pop_check8(input string nm);
        if (sb8.size() == 0) begin
            check({nm, "_sb_empty"}, 1, 0);
        end else begin
            check(nm, o_state, sb8.pop_front());
        end
    endtask

    // One full transaction on the NB_SBOX=8 instance with immediate handshake.
    task automatic send8(input t_state_array din, input t_state_array dexp, input string nm);
        int edges;
        @(negedge clock);
        check({nm, "_ready"}, o_ready, 1);
        i_valid = 1'b1;
        i_state = din;
        sb8.push_back(dexp);
        @(posedge clock);
        #1;
        i_valid = 1'b0;
        i_state = rand_state();
        edges = 1;
        @(negedge clock);
        check({nm, "_busy"}, {o_busy, o_ready}, 2'b10);
        while (!o_valid && edges < 200) begin
            @(posedge clock);
            edges++;
            @(negedge clock);
        end
        check({nm, "_latency"}, edges, NSTEPS + 1);
        if (o_valid) begin
            pop_check8({nm, "_data"});
            i_ready = 1'b1;
            @(posedge clock);
            #1;
            i_ready = 1'b0;
            @(negedge clock);
            check({nm, "_post_hs"}, {o_valid, o_ready}, 2'b01);
            check({nm, "_post_hs_state"}, o_state, after_hs(dexp));
        end
    endtask

    task automatic send_aux(input t_state_array din, input string nm);
        int edges, e1, e64;
        @(negedge clock);
        va = 1'b1;
        sa = din;
        sb1.push_back(ref_subst(din));
        sb64.push_back(ref_subst(din));
        @(posedge clock);
        #1;
        va = 1'b0;
        sa = rand_state();
        edges = 1;
        e1 = 0;
        e64 = 0;
        @(negedge clock);
        while ((e1 == 0 || e64 == 0) && edges < 200) begin
            if (ov1 && e1 == 0) begin
                e1 = edges;
                check({nm, "_nb1_data"}, os1, sb1.pop_front());
            end
            if (ov64 && e64 == 0) begin
                e64 = edges;
                check({nm, "_nb64_data"}, os64, sb64.pop_front());
            end
            if (e1 == 0 || e64 == 0) begin
                @(posedge clock);
                edges++;
                @(negedge clock);
            end
        end
        check({nm, "_nb1_latency"}, e1, 65);
        check({nm, "_nb64_latency"}, e64, 2);
    endtask

    initial begin
        t_state_array snap, b1, b2;
        logic stable, seen;
        int acc, hs, hs1_at, acc2_at;

        vecs[0] = '{mk(0, 0, 0, 0, 0),       mk(0, 0, C_F, 0, 0)};
        vecs[1] = '{mk(C_F, C_F, C_F, C_F, C_F), mk(C_F, 0, C_F, C_F, C_F)};
        vecs[2] = '{mk(C_F, 0, 0, 0, 0),     mk(C_F, C_F, C_F, C_F, 0)};
        vecs[3] = '{mk(0, 0, 0, 0, C_F),     mk(0, C_F, 0, C_F, C_F)};
        vecs[4] = '{mk(C_A, 0, 0, 0, 0),     mk(C_A, C_A, C_F, C_A, 0)};
        for (int i = 5; i < 7; i++) begin
            vecs[i].din  = rand_state();
            vecs[i].dexp = ref_subst(vecs[i].din);
        end

        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset_flags", {o_ready, o_valid, o_busy}, 3'b100);
        check("reset_state", o_state, '0);
        check("reset_aux_flags", {ordy1, ov1, ob1, ordy64, ov64, ob64}, 6'b100100);
        reset_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            send8(vecs[i].din, vecs[i].dexp, $sformatf("vec%0d", i));
        end

        // Stall in DONE with i_valid held high throughout.
        b1 = rand_state();
        @(negedge clock);
        i_valid = 1'b1;
        i_state = b1;
        sb8.push_back(ref_subst(b1));
        @(posedge clock);
        #1;
        i_state = rand_state();
        for (int c = 0; c < 200 && !o_valid; c++) @(negedge clock);
        @(negedge clock);
        check("stall_valid", o_valid, 1);
        snap = o_state;
        stable = 1'b1;
        repeat (20) begin
            @(posedge clock);
            @(negedge clock);
            if (o_state !== snap || o_ready !== 1'b0 || o_valid !== 1'b1) stable = 1'b0;
        end
        check("stall_stable", stable, 1);
        pop_check8("stall_data");
        i_ready = 1'b1;
        @(posedge clock);
        #1;
        i_ready = 1'b0;
        @(negedge clock);
        check("stall_hs_no_accept", {o_ready, o_busy, o_valid}, 3'b100);
        check("stall_hs_state", o_state, after_hs(ref_subst(b1)));
        i_valid = 1'b0;

        for (int i = 0; i < 3; i++) send_aux(rand_state(), $sformatf("aux%0d", i));

        // Reset during SUBST with cnt = 3.
        @(negedge clock);
        i_valid = 1'b1;
        i_state = rand_state();
        @(posedge clock);
        #1;
        i_valid = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_mid_busy", o_busy, 1);
        reset_n = 1'b0;
        #1;
        check("rst_mid_flags", {o_ready, o_valid, o_busy}, 3'b100);
        check("rst_mid_state", o_state, '0);
        @(negedge clock);
        reset_n = 1'b1;
        seen = 1'b0;
        repeat (30) begin
            @(negedge clock);
            if (o_valid) seen = 1'b1;
        end
        check("rst_no_valid", seen, 0);

        // Back-to-back with i_valid and i_ready held high.
        b1 = rand_state();
        b2 = rand_state();
        acc = 0;
        hs = 0;
        hs1_at = -1;
        acc2_at = -1;
        @(negedge clock);
        i_valid = 1'b1;
        i_state = b1;
        i_ready = 1'b1;
        for (int cyc = 0; cyc < 60 && hs < 2; cyc++) begin
            if (o_ready && i_valid) begin
                sb8.push_back(ref_subst(i_state));
                acc++;
                if (acc == 2) acc2_at = cyc;
            end
            if (o_valid && i_ready) begin
                pop_check8($sformatf("b2b_data%0d", hs));
                hs++;
                if (hs == 1) hs1_at = cyc;
            end
            @(posedge clock);
            #1;
            if (acc == 1) i_state = b2;
            if (acc >= 2) i_valid = 1'b0;
            @(negedge clock);
        end
        i_ready = 1'b0;
        check("b2b_handshakes", hs, 2);
        check("b2b_second_accept", acc2_at, hs1_at + 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got time limit reached, expected end of test");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
